// File: rtl/cjb_mem_arb_pkg.sv
// Shared types and constants for the CPU/DMA main-memory arbiter.
package cjb_mem_arb_pkg;

  localparam int DEFAULT_AW = 10;
  localparam int DEFAULT_DW = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Every access walks IDLE -> GNT_x -> ACK_x -> IDLE.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GNT_CPU = 3'd1,
    GNT_DMA = 3'd2,
    ACK_CPU = 3'd3,
    ACK_DMA = 3'd4
  } arb_state_e;

endpackage

// File: rtl/cjb_arb_starve_cnt.sv
// Saturating count of CPU wins taken while the DMA port was waiting.
module cjb_arb_starve_cnt #(
  parameter int LIMIT = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         inc,
  input  logic                         clr,
  output logic [$clog2(LIMIT+1)-1:0]   cnt,
  output logic                         at_limit
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt_reg;

  // Clear wins over increment; increment stops at LIMIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != LIMIT_C)) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign cnt      = cnt_reg;
  assign at_limit = (cnt_reg == LIMIT_C);

endmodule

// File: rtl/cjb_mem_arbiter.sv
// Single-port main-memory arbiter: CPU has fixed priority, a starvation
// counter forces one DMA win after STARVE_LIMIT back-to-back CPU wins.
module cjb_mem_arbiter
  import cjb_mem_arb_pkg::*;
#(
  parameter int AW           = DEFAULT_AW,
  parameter int DW           = DEFAULT_DW,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_rw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_rw,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          gnt_cpu,
  output logic          gnt_dma
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  arb_state_e    state_reg;
  logic          acc_rw_reg;
  logic          cpu_ack_reg, dma_ack_reg;
  logic          mem_en_reg, mem_rw_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_wdata_reg;
  logic          gnt_cpu_reg, gnt_dma_reg;
  logic [DW-1:0] cpu_rdata_reg, dma_rdata_reg;

  logic [CW-1:0] starve_cnt;
  logic          starve_at_limit;
  logic          in_idle, pick_dma, pick_cpu;
  logic          starve_inc, starve_clr;

  // DMA wins in IDLE when it is alone, or when the CPU has starved it long enough.
  assign in_idle    = (state_reg == IDLE);
  assign pick_dma   = dma_req & (~cpu_req | starve_at_limit);
  assign pick_cpu   = cpu_req & ~pick_dma;
  assign starve_inc = in_idle & pick_cpu & dma_req;
  assign starve_clr = in_idle & (pick_dma | ~dma_req);

  cjb_arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .cnt      (starve_cnt),
    .at_limit (starve_at_limit)
  );

  // Arbitration FSM with registered memory strobes, grants and acks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_rw_reg    <= RW_READ;
      cpu_ack_reg   <= 1'b0;
      dma_ack_reg   <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_rw_reg    <= RW_READ;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      gnt_cpu_reg   <= 1'b0;
      gnt_dma_reg   <= 1'b0;
      cpu_rdata_reg <= '0;
      dma_rdata_reg <= '0;
    end else begin
      // Idle bus values unless a grant is being issued this edge.
      cpu_ack_reg   <= 1'b0;
      dma_ack_reg   <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_rw_reg    <= RW_READ;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      gnt_cpu_reg   <= 1'b0;
      gnt_dma_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_dma) begin
            state_reg     <= GNT_DMA;
            acc_rw_reg    <= dma_rw;
            mem_en_reg    <= 1'b1;
            mem_rw_reg    <= dma_rw;
            mem_addr_reg  <= dma_addr;
            mem_wdata_reg <= dma_wdata;
            gnt_dma_reg   <= 1'b1;
          end else if (pick_cpu) begin
            state_reg     <= GNT_CPU;
            acc_rw_reg    <= cpu_rw;
            mem_en_reg    <= 1'b1;
            mem_rw_reg    <= cpu_rw;
            mem_addr_reg  <= cpu_addr;
            mem_wdata_reg <= cpu_wdata;
            gnt_cpu_reg   <= 1'b1;
          end
        end
        GNT_CPU: begin
          state_reg   <= ACK_CPU;
          cpu_ack_reg <= 1'b1;
        end
        GNT_DMA: begin
          state_reg   <= ACK_DMA;
          dma_ack_reg <= 1'b1;
        end
        ACK_CPU: begin
          state_reg <= IDLE;
          if (acc_rw_reg == RW_READ) cpu_rdata_reg <= mem_rdata;
        end
        ACK_DMA: begin
          state_reg <= IDLE;
          if (acc_rw_reg == RW_READ) dma_rdata_reg <= mem_rdata;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Read data arrives from the macro during the ACK cycle, so it is passed
  // straight through while ack is high and held in the register afterwards.
  assign cpu_rdata = (state_reg == ACK_CPU && acc_rw_reg == RW_READ) ? mem_rdata : cpu_rdata_reg;
  assign dma_rdata = (state_reg == ACK_DMA && acc_rw_reg == RW_READ) ? mem_rdata : dma_rdata_reg;

  assign cpu_ack   = cpu_ack_reg;
  assign dma_ack   = dma_ack_reg;
  assign cpu_stall = cpu_req & ~cpu_ack_reg;
  assign mem_en    = mem_en_reg;
  assign mem_rw    = mem_rw_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign gnt_cpu   = gnt_cpu_reg;
  assign gnt_dma   = gnt_dma_reg;

endmodule

// File: doc/cjb_mem_arbiter.md
Name: cjb_mem_arbiter

Overview:
- Arbitrates the single-port 1K x 8 main memory between two requesters: the CPU data path (MAR/RW path, driven by the CU) and a DMA/debug loader port.
- Sits between the DP memory interface and the memory macro.
- Uses a req/ack handshake on both sides; the CPU stalls while its request is pending.
- Fixed CPU priority, with a starvation guard that guarantees DMA progress.

Parameters:
- AW, 10, address width (matches MARout).
- DW, 8, data width.
- STARVE_LIMIT, 3, consecutive CPU grants allowed while dma_req is pending before DMA is forced to win once.

Ports:
- Clock  in  1  system clock; all logic is rising-edge.
- Reset  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_rw  in  1  1=read, 0=write.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data; valid while cpu_ack=1.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational), to the CU.
- dma_req, dma_rw, dma_addr, dma_wdata  in  1/1/AW/DW  DMA request, same rules as the CPU side.
- dma_rdata  out  DW  DMA read data.
- dma_ack  out  1  DMA completion pulse.
- mem_en  out  1  memory access strobe.
- mem_rw  out  1  1=read, 0=write.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid the cycle after mem_en with mem_rw=1.
- gnt_cpu, gnt_dma  out  1  current-owner indicators, for debug.

Behaviour:
- FSM states: IDLE, GNT_CPU, GNT_DMA, ACK_CPU, ACK_DMA. Every access takes exactly 3 cycles: IDLE -> GNT -> ACK -> IDLE.
- IDLE:
  - Only cpu_req -> GNT_CPU; only dma_req -> GNT_DMA.
  - Both asserted -> GNT_CPU, unless starve_cnt == STARVE_LIMIT, in which case -> GNT_DMA.
  - Neither -> stay in IDLE.
- GNT_x:
  - mem_en=1 for exactly this one cycle.
  - mem_addr/mem_rw/mem_wdata driven from the granted port; gnt_x=1.
  - Next state is ACK_x unconditionally.
- ACK_x:
  - x_ack=1 for this one cycle.
  - On a read, x_rdata is captured from mem_rdata and held until the next ack on that port. On a write, x_rdata keeps its old value.
  - Next state is IDLE.
- Handshake rules:
  - A requester holds req, rw, addr and wdata stable from assertion until the edge at which it samples ack=1.
  - At that edge it either drops req, or keeps it high only to start a new access.
  - A req seen in IDLE is always treated as a new request.
  - Dropping req before ack is illegal; the arbiter completes the access regardless.
- Starvation counter:
  - Increments on each IDLE -> GNT_CPU transition while dma_req=1, saturating at STARVE_LIMIT.
  - Clears on IDLE -> GNT_DMA, or whenever dma_req=0 in IDLE.
- mem_* when not granted: mem_en=0, mem_rw=1, mem_addr=0, mem_wdata=0. Memory is never written outside a GNT state.
- Reset values (Reset=0 at a Clock edge):
  - State -> IDLE; starve_cnt=0.
  - All acks, mem_en, gnt_* = 0; mem_rw=1; cpu_rdata = dma_rdata = 0.
- Reset during GNT_x or ACK_x abandons the access, and no ack is issued afterwards. A write strobed in GNT_x before the reset edge remains in memory.
- Widths: no arithmetic on addresses or data; starve_cnt is $clog2(STARVE_LIMIT+1) bits.

Decomposition:
- Package cjb_mem_arb_pkg holds:
  - the state enum (5 states, binary-encoded);
  - RW_READ=1'b1 and RW_WRITE=1'b0;
  - default AW/DW.
- One natural sub-module, cjb_arb_starve_cnt: the saturating counter with inc/clr/at_limit. The FSM and the mux stay in the top module.

Test Plan:
1. Hold Reset=0 for 2 cycles with both reqs high -> mem_en=0, acks=0, mem_rw=1, rdata=0; first grant appears 2 cycles after Reset rises.
2. CPU read, cpu_addr=0x155, memory returns 0xA5 -> mem_en=1 with mem_addr=0x155 in cycle 2; cpu_ack=1 and cpu_rdata=0xA5 in cycle 3; cpu_stall=1 in cycles 1-2.
3. DMA write, dma_addr=0x3FF, wdata=0x3C -> a single-cycle mem_en with mem_rw=0, mem_addr=0x3FF, mem_wdata=0x3C; dma_ack in the following cycle; cpu_ack stays 0.
4. Both reqs raised together, CPU re-requesting back-to-back, dma_req held high, STARVE_LIMIT=3 -> grant order CPU, CPU, CPU, DMA, CPU; starve_cnt reads 0 after the DMA grant.
5. Reset=0 asserted in the GNT_DMA cycle of a write -> the write is visible in memory, no dma_ack ever, FSM in IDLE; a new cpu_req is serviced normally afterwards.
6. Two consecutive CPU reads, returning 0x11 then 0x22 -> the second mem_en occurs exactly 3 cycles after the first; cpu_rdata holds 0x11 until the second ack, then shows 0x22.
